// File: rtl/ncc_corr_strip.sv
// rtl/ncc_corr_strip.sv - sliding-window normalized cross-correlation strip engine
module ncc_corr_strip #(
    parameter int DIM    = 16,
    parameter int PIX_W  = 8,
    parameter int DESC_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 24,
    parameter int X_W    = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [LANES*DESC_W-1:0] desc_data,
    input  logic                    desc_reload,
    input  logic                    col_valid,
    output logic                    col_ready,
    input  logic [DIM*PIX_W-1:0]    col_data,
    input  logic                    col_last,
    output logic                    score_valid,
    output logic [ACC_W-1:0]        score,
    output logic [X_W-1:0]          score_x,
    output logic                    peak_valid,
    output logic [ACC_W-1:0]        peak_score,
    output logic [X_W-1:0]          peak_x
);

    localparam int NELEM  = DIM * DIM;
    localparam int NWORDS = NELEM / LANES;
    localparam int WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PROD_W = PIX_W + DESC_W + 1;

    localparam logic signed [ACC_W-1:0] PK_INIT   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic        [X_W-1:0]   PK_X_INIT = '1;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WC_W-1:0]              r_word_cnt;
    logic [X_W-1:0]               r_xin;
    logic [1:0]                   r_drain_cnt;
    logic                         r_reload_pend;
    logic signed [DESC_W-1:0]     r_desc [NELEM];
    logic [DIM*PIX_W-1:0]         r_win  [DIM];
    logic [DIM*PIX_W-1:0]         w_win_next [DIM];

    logic signed [PROD_W-1:0]     r_prod [NELEM];
    logic signed [PROD_W-1:0]     w_prod_next [NELEM];
    logic                         r_s1_valid;
    logic [X_W-1:0]               r_s1_x;
    logic signed [ACC_W-1:0]      w_sum;

    logic                         r_score_valid;
    logic signed [ACC_W-1:0]      r_score;
    logic [X_W-1:0]               r_score_x;

    logic signed [ACC_W-1:0]      r_pk_score;
    logic [X_W-1:0]               r_pk_x;
    logic                         w_pk_take;
    logic signed [ACC_W-1:0]      w_pk_score_sel;
    logic [X_W-1:0]               w_pk_x_sel;

    logic                         r_peak_valid;
    logic [ACC_W-1:0]             r_peak_score;
    logic [X_W-1:0]               r_peak_x;

    logic                         w_desc_acc;
    logic                         w_col_acc;
    logic                         w_load_done;
    logic                         w_drain_peak;
    logic                         w_drain_done;
    logic                         w_emit;

    // Signed product of a zero-extended pixel and a descriptor element
    function automatic logic signed [PROD_W-1:0] mul_px(
        input logic [PIX_W-1:0]         p,
        input logic signed [DESC_W-1:0] d
    );
        logic signed [PROD_W-1:0] pe;
        logic signed [PROD_W-1:0] de;
        pe = $signed({{(PROD_W-PIX_W){1'b0}}, p});
        de = $signed({{(PROD_W-DESC_W){d[DESC_W-1]}}, d});
        return pe * de;
    endfunction

    assign desc_ready   = (r_state == S_LOAD);
    assign col_ready    = (r_state == S_RUN);
    assign w_desc_acc   = desc_valid && (r_state == S_LOAD);
    assign w_col_acc    = col_valid && (r_state == S_RUN);
    assign w_load_done  = w_desc_acc && (r_word_cnt == WC_W'(NWORDS - 1));
    assign w_drain_peak = (r_state == S_DRAIN) && (r_drain_cnt == 2'd1);
    assign w_drain_done = (r_state == S_DRAIN) && (r_drain_cnt == 2'd2);
    assign w_emit       = w_col_acc && (r_xin >= X_W'(DIM - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a column accepted at xin=0 keeps the strip going over a pending reload
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_load_done) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_col_acc) begin
                    if (col_last) begin
                        w_state_next = S_DRAIN;
                    end
                end else if (r_reload_pend && (r_xin == '0)) begin
                    w_state_next = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (w_drain_done) begin
                    w_state_next = r_reload_pend ? S_LOAD : S_RUN;
                end
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    // Reload request latch, consumed on entry to LOAD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reload_pend <= 1'b0;
        end else if ((r_state != S_LOAD) && (w_state_next == S_LOAD)) begin
            r_reload_pend <= 1'b0;
        end else if (desc_reload && (r_state != S_LOAD)) begin
            r_reload_pend <= 1'b1;
        end
    end

    // Descriptor word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_desc_acc) begin
            r_word_cnt <= w_load_done ? '0 : r_word_cnt + 1'b1;
        end
    end

    // Descriptor memory: word w fills elements w*LANES .. w*LANES+LANES-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NELEM; i++) begin
                r_desc[i] <= '0;
            end
        end else if (w_desc_acc) begin
            for (int l = 0; l < LANES; l++) begin
                r_desc[int'(r_word_cnt) * LANES + l] <= desc_data[l*DESC_W +: DESC_W];
            end
        end
    end

    // Strip column counter and drain sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xin       <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_drain_done) begin
                r_xin <= '0;
            end else if (w_col_acc) begin
                r_xin <= r_xin + 1'b1;
            end
            if (r_state == S_DRAIN) begin
                r_drain_cnt <= w_drain_done ? 2'd0 : r_drain_cnt + 2'd1;
            end else begin
                r_drain_cnt <= 2'd0;
            end
        end
    end

    // Window as it will look once the incoming column has shifted in
    always_comb begin
        for (int c = 0; c < DIM; c++) begin
            w_win_next[c] = '0;
        end
        for (int c = 0; c < DIM - 1; c++) begin
            w_win_next[c] = r_win[c+1];
        end
        w_win_next[DIM-1] = col_data;
    end

    // Window buffer; emptied at the end of every strip
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < DIM; c++) begin
                r_win[c] <= '0;
            end
        end else if (w_drain_done) begin
            for (int c = 0; c < DIM; c++) begin
                r_win[c] <= '0;
            end
        end else if (w_col_acc) begin
            for (int c = 0; c < DIM; c++) begin
                r_win[c] <= w_win_next[c];
            end
        end
    end

    // Element products against the post-shift window
    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                w_prod_next[r*DIM + c] = mul_px(w_win_next[c][r*PIX_W +: PIX_W], r_desc[r*DIM + c]);
            end
        end
    end

    // Stage 1: register products and the window position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            for (int i = 0; i < NELEM; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_s1_valid <= w_emit;
            if (w_emit) begin
                r_s1_x <= r_xin - X_W'(DIM - 1);
                for (int i = 0; i < NELEM; i++) begin
                    r_prod[i] <= w_prod_next[i];
                end
            end
        end
    end

    // Exact adder tree over all products, sign-extended to the score width
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NELEM; i++) begin
            w_sum = w_sum + {{(ACC_W-PROD_W){r_prod[i][PROD_W-1]}}, r_prod[i]};
        end
    end

    // Stage 2: register score; value and position hold between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_score_valid <= 1'b0;
            r_score       <= '0;
            r_score_x     <= '0;
        end else begin
            r_score_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_score   <= w_sum;
                r_score_x <= r_s1_x;
            end
        end
    end

    // Strictly-greater compare keeps the earliest position on ties
    assign w_pk_take      = r_score_valid && (r_score > r_pk_score);
    assign w_pk_score_sel = w_pk_take ? r_score   : r_pk_score;
    assign w_pk_x_sel     = w_pk_take ? r_score_x : r_pk_x;

    // Running peak tracker, re-armed after each strip
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pk_score <= PK_INIT;
            r_pk_x     <= PK_X_INIT;
        end else if (w_drain_done) begin
            r_pk_score <= PK_INIT;
            r_pk_x     <= PK_X_INIT;
        end else begin
            r_pk_score <= w_pk_score_sel;
            r_pk_x     <= w_pk_x_sel;
        end
    end

    // Peak report lands in the last drain cycle, folding in the strip's final score
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peak_valid <= 1'b0;
            r_peak_score <= '0;
            r_peak_x     <= '0;
        end else begin
            r_peak_valid <= w_drain_peak;
            if (w_drain_peak) begin
                r_peak_score <= w_pk_score_sel;
                r_peak_x     <= w_pk_x_sel;
            end
        end
    end

    assign score_valid = r_score_valid;
    assign score       = r_score;
    assign score_x     = r_score_x;
    assign peak_valid  = r_peak_valid;
    assign peak_score  = r_peak_score;
    assign peak_x      = r_peak_x;

endmodule

// File: tb/tb_ncc_corr_strip.sv
// tb/tb_ncc_corr_strip.sv - scoreboard bench for ncc_corr_strip
module tb_ncc_corr_strip;

    localparam int DIM    = 4;
    localparam int PIX_W  = 8;
    localparam int DESC_W = 8;
    localparam int LANES  = 4;
    localparam int ACC_W  = 24;
    localparam int X_W    = 11;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     desc_valid = 1'b0;
    logic                     desc_ready;
    logic [LANES*DESC_W-1:0]  desc_data = '0;
    logic                     desc_reload = 1'b0;
    logic                     col_valid = 1'b0;
    logic                     col_ready;
    logic [DIM*PIX_W-1:0]     col_data = '0;
    logic                     col_last = 1'b0;
    logic                     score_valid;
    logic signed [ACC_W-1:0]  score;
    logic [X_W-1:0]           score_x;
    logic                     peak_valid;
    logic signed [ACC_W-1:0]  peak_score;
    logic [X_W-1:0]           peak_x;

    ncc_corr_strip #(
        .DIM(DIM), .PIX_W(PIX_W), .DESC_W(DESC_W),
        .LANES(LANES), .ACC_W(ACC_W), .X_W(X_W)
    ) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
        .desc_reload(desc_reload),
        .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data), .col_last(col_last),
        .score_valid(score_valid), .score(score), .score_x(score_x),
        .peak_valid(peak_valid), .peak_score(peak_score), .peak_x(peak_x)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [ACC_W-1:0] v;
        logic [X_W-1:0]          x;
        int                      c;
    } exp_t;

    exp_t sq[$];
    exp_t pq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_acc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes a result
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (score_valid) begin
                check("score_expected", sq.size() > 0, 1);
                if (sq.size() > 0) begin
                    e = sq.pop_front();
                    check("score", score, e.v);
                    check("score_x", score_x, e.x);
                    check("score_cycle", cyc, e.c);
                end
            end
            if (peak_valid) begin
                check("peak_expected", pq.size() > 0, 1);
                if (pq.size() > 0) begin
                    e = pq.pop_front();
                    check("peak_score", peak_score, e.v);
                    check("peak_x", peak_x, e.x);
                    check("peak_cycle", cyc, e.c);
                end
            end
        end
    end

    task automatic load_word(input logic [31:0] w);
        int t = 0;
        desc_data  = w;
        desc_valid = 1'b1;
        while (!desc_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("desc_ready_wait", desc_ready, 1);
        @(posedge clk); #1;
        desc_valid = 1'b0;
    endtask

    task automatic load_desc(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        load_word(w0);
        load_word(w1);
        load_word(w2);
        load_word(w3);
    endtask

    task automatic pulse_reload();
        desc_reload = 1'b1;
        @(posedge clk); #1;
        desc_reload = 1'b0;
    endtask

    task automatic reload_wait();
        int t = 0;
        pulse_reload();
        while (!desc_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("reload_to_load", desc_ready, 1);
    endtask

    task automatic send_col(input logic [31:0] d, input logic last,
                            input bit has_exp, input int ev, input int ex);
        int t = 0;
        col_data  = d;
        col_last  = last;
        col_valid = 1'b1;
        while (!col_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!col_ready) begin
            check("col_ready_wait", col_ready, 1);
            col_valid = 1'b0;
            col_last  = 1'b0;
            return;
        end
        @(posedge clk); #1;
        last_acc  = cyc;
        col_valid = 1'b0;
        col_last  = 1'b0;
        if (has_exp) sq.push_back('{v: ACC_W'(ev), x: X_W'(ex), c: cyc + 1});
    endtask

    task automatic push_peak(input int ev, input int ex);
        pq.push_back('{v: ACC_W'(ev), x: X_W'(ex), c: last_acc + 2});
    endtask

    task automatic wait_drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 remaining", sq.size() + pq.size());
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int vals3[7];
        vals3 = '{5, 9, 2, 9, 7, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_desc_ready", desc_ready, 1);
        check("rst_col_ready", col_ready, 0);
        check("rst_score_valid", score_valid, 0);
        check("rst_score", score, 0);
        check("rst_score_x", score_x, 0);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_peak_score", peak_score, 0);
        check("rst_peak_x", peak_x, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-ones descriptor, unit pixels: 16 everywhere, peak at first position
        load_desc(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
        check("run_col_ready", col_ready, 1);
        for (int k = 0; k < 6; k++) send_col(32'h01010101, k == 5, k >= 3, 16, k - 3);
        push_peak(16, 0);
        wait_drain();

        // Negative descriptor against saturated pixels
        reload_wait();
        load_desc(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 0; k < 5; k++) send_col(32'hFFFFFFFF, k == 4, k >= 3, -4080, k - 3);
        push_peak(-4080, 0);
        wait_drain();

        // Single-tap descriptor picks row 0 of the oldest column; tie at x=3 ignored
        reload_wait();
        load_desc(32'h00000001, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 7; k++) send_col(32'(vals3[k]), k == 6, k >= 3, (k >= 3) ? vals3[k-3] : 0, k - 3);
        push_peak(9, 1);
        wait_drain();

        // Strip shorter than the window: no scores, initial peak values
        for (int k = 0; k < 3; k++) send_col(32'h01010101, k == 2, 1'b0, 0, 0);
        push_peak(-8388608, 2047);
        wait_drain();

        // Reload mid-strip: strip finishes on the old descriptor, then LOAD
        for (int k = 0; k < 6; k++) begin
            send_col(32'(10 + k), k == 5, k >= 3, 10 + k - 3, k - 3);
            if (k == 1) pulse_reload();
        end
        push_peak(12, 2);
        repeat (3) @(posedge clk);
        #1;
        check("post_reload_desc_ready", desc_ready, 1);
        check("post_reload_col_ready", col_ready, 0);
        load_desc(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);

        // Gapped column stream: scores contiguous in x, each two cycles after its column
        for (int k = 0; k < 6; k++) begin
            send_col({4{8'(k + 1)}}, k == 5, k >= 3, 16 * (k - 3) + 40, k - 3);
            @(posedge clk); #1;
        end
        push_peak(72, 2);
        wait_drain();

        // Asynchronous reset mid-strip with a score in flight
        for (int k = 0; k < 5; k++) send_col(32'h02020202, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        sq.delete();
        pq.delete();
        #1;
        check("arst_desc_ready", desc_ready, 1);
        check("arst_col_ready", col_ready, 0);
        check("arst_score_valid", score_valid, 0);
        check("arst_score", score, 0);
        check("arst_score_x", score_x, 0);
        check("arst_peak_valid", peak_valid, 0);
        check("arst_peak_score", peak_score, 0);
        check("arst_peak_x", peak_x, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("final_desc_ready", desc_ready, 1);
        check("score_queue_drained", sq.size(), 0);
        check("peak_queue_drained", pq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
